// File: rtl/rv32imf_apu_arbiter.sv
// Round-robin arbiter sharing one FP wrapper among NUM_REQ APU requesters, with an
// in-order ID FIFO for result routing. Define RV32IMF_APU_ARB_PRIO_EN for strict requester-0 priority.
module rv32imf_apu_arbiter #(
    parameter int unsigned NUM_REQ         = 2,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NUM_REQ-1:0]                req_i,
    output logic [NUM_REQ-1:0]                gnt_o,
    input  logic [NUM_REQ-1:0][2:0][31:0]     operands_i,
    input  logic [NUM_REQ-1:0][5:0]           op_i,
    input  logic [NUM_REQ-1:0][14:0]          flags_i,
    output logic [NUM_REQ-1:0]                rvalid_o,
    output logic [31:0]                       rdata_o,
    output logic [4:0]                        rflags_o,
    output logic                              fpu_req_o,
    input  logic                              fpu_gnt_i,
    output logic [2:0][31:0]                  fpu_operands_o,
    output logic [5:0]                        fpu_op_o,
    output logic [14:0]                       fpu_flags_o,
    input  logic                              fpu_rvalid_i,
    input  logic [31:0]                       fpu_rdata_i,
    input  logic [4:0]                        fpu_rflags_i,
    output logic                              busy_o,
    output logic                              err_o
);

    localparam int unsigned IdW  = $clog2(NUM_REQ);
    localparam int unsigned PtrW = $clog2(MAX_OUTSTANDING);
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic {
        UNLOCKED,
        LOCKED
    } lock_state_e;

    typedef logic [IdW-1:0] id_t;

    lock_state_e     state_q, state_d;
    id_t             locked_id_q, locked_id_d;
    id_t             rr_ptr_q, rr_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;
    id_t             fifo_q [MAX_OUTSTANDING];

    id_t             sel;
    id_t             head;
    logic            full;
    logic            empty;
    logic            fpu_req;
    logic            handshake;
    logic            push;
    logic            pop;

    // First set bit of req at or above ptr, wrapping; returns ptr when nothing is requested.
    function automatic id_t rr_pick(input logic [NUM_REQ-1:0] req, input id_t ptr);
        id_t         pick;
        logic        found;
        int unsigned idx;
        pick  = ptr;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = (32'(ptr) + i) % NUM_REQ;
            if (!found && req[idx]) begin
                pick  = id_t'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign full  = (cnt_q == CntW'(MAX_OUTSTANDING));
    assign empty = (cnt_q == '0);
    assign head  = fifo_q[rd_ptr_q];

    always_comb begin
        if (state_q == LOCKED) begin
            sel = locked_id_q;
`ifdef RV32IMF_APU_ARB_PRIO_EN
        end else if (req_i[0]) begin
            sel = '0;
        end else begin
            sel = rr_pick(req_i & ~NUM_REQ'(1), rr_ptr_q);
`else
        end else begin
            sel = rr_pick(req_i, rr_ptr_q);
`endif
        end
    end

    // No full-bypass: a pop in the same cycle does not free a slot until the next cycle.
    assign fpu_req   = req_i[sel] & ~full;
    assign handshake = fpu_req & fpu_gnt_i;
    assign push      = handshake;
    assign pop       = fpu_rvalid_i & ~empty;

    assign fpu_operands_o = operands_i[sel];
    assign fpu_op_o       = op_i[sel];
    assign fpu_flags_o    = flags_i[sel];
    assign rdata_o        = fpu_rdata_i;
    assign rflags_o       = fpu_rflags_i;

    // Outputs are forced low while reset is held so the clock gate closes immediately.
    always_comb begin
        gnt_o    = '0;
        rvalid_o = '0;
        if (!rst_i) begin
            gnt_o[sel]     = handshake;
            rvalid_o[head] = pop;
        end
    end

    assign fpu_req_o = fpu_req & ~rst_i;
    assign busy_o    = ((cnt_q != '0) | (|req_i)) & ~rst_i;
    assign err_o     = err_q;

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        locked_id_d = locked_id_q;
        rr_ptr_d    = rr_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q;
        err_d       = err_q;

        unique case (state_q)
            UNLOCKED: begin
                if (fpu_req && !fpu_gnt_i) begin
                    state_d     = LOCKED;
                    locked_id_d = sel;
                end
            end
            LOCKED: begin
                if (!req_i[locked_id_q]) begin
                    state_d = UNLOCKED;
                    err_d   = 1'b1;
                end else if (handshake) begin
                    state_d = UNLOCKED;
                end
            end
            default: state_d = UNLOCKED;
        endcase

`ifdef RV32IMF_APU_ARB_PRIO_EN
        if (handshake && sel != '0) begin
`else
        if (handshake) begin
`endif
            rr_ptr_d = id_t'((32'(sel) + 32'd1) % NUM_REQ);
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        if (push && !pop) begin
            cnt_d = cnt_q + CntW'(1);
        end else if (pop && !push) begin
            cnt_d = cnt_q - CntW'(1);
        end

        if (fpu_rvalid_i && empty) begin
            err_d = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= UNLOCKED;
            locked_id_q <= '0;
            rr_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            locked_id_q <= locked_id_d;
            rr_ptr_q    <= rr_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
        end
    end

    // NOTE: FIFO storage is not reset; entries are only read when cnt_q says they are valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= sel;
        end
    end

endmodule

// File: doc/rv32imf_apu_arbiter.md
Name: rv32imf_apu_arbiter

Overview:
- Shares one rv32imf_fp_wrapper instance between NUM_REQ APU requesters, for example several cores or a core plus an accelerator.
- Round-robin arbitration on the request/grant channel.
- An in-order ID FIFO routes each result back to the requester that issued it.
- Sits between the requesters' apu_* ports and the FP wrapper. Its busy output drives the FP clock-gate enable.

Parameters:
- NUM_REQ, 2, number of requesters; legal range 2..8.
- MAX_OUTSTANDING, 4, depth of the ID FIFO, i.e. maximum granted-but-unanswered operations; power of 2, at least 2.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- req_i  in  NUM_REQ  per-requester APU request.
- gnt_o  out  NUM_REQ  per-requester grant.
- operands_i  in  NUM_REQ x 3 x 32  per-requester operands.
- op_i  in  NUM_REQ x 6  per-requester opcode.
- flags_i  in  NUM_REQ x 15  per-requester flags.
- rvalid_o  out  NUM_REQ  per-requester result valid.
- rdata_o  out  32  result data, broadcast to all requesters.
- rflags_o  out  5  result exception flags, broadcast to all requesters.
- fpu_req_o  out  1  request to the FP wrapper.
- fpu_gnt_i  in  1  grant from the FP wrapper.
- fpu_operands_o  out  3 x 32  operands to the FP wrapper.
- fpu_op_o  out  6  opcode to the FP wrapper.
- fpu_flags_o  out  15  flags to the FP wrapper.
- fpu_rvalid_i  in  1  result valid from the FP wrapper.
- fpu_rdata_i  in  32  result data from the FP wrapper.
- fpu_rflags_i  in  5  result flags from the FP wrapper.
- busy_o  out  1  request or operation pending; drives the clock-gate enable.
- err_o  out  1  sticky protocol error.

Behaviour:
- Reset (rst_i high, asynchronous):
  - rr_ptr=0, lock=0, locked_id=0, FIFO empty (count=0, rd/wr pointers 0), err_o=0.
  - All outputs 0: fpu_req_o, gnt_o, rvalid_o, busy_o.
  - Reset asserted mid-operation discards in-flight IDs. Results arriving after reset release raise err_o, because the FIFO is empty.
- Selection (combinational), sel:
  - If lock=1: sel=locked_id.
  - Otherwise: the first requester with req_i set, scanning from rr_ptr upward with wrap NUM_REQ-1 -> 0.
- Forwarding:
  - fpu_req_o = req_i[sel] & !full.
  - fpu_operands_o, fpu_op_o and fpu_flags_o are muxed from sel.
  - gnt_o[sel] = fpu_gnt_i & fpu_req_o; all other gnt_o bits are 0.
  - Zero-cycle grant path: a requester sees grant in the same cycle the FP wrapper grants.
- Lock state machine, two states:
  - UNLOCKED -> LOCKED when fpu_req_o=1 and fpu_gnt_i=0; records locked_id=sel.
  - LOCKED -> UNLOCKED on handshake (fpu_req_o & fpu_gnt_i).
  - If req_i[locked_id] drops while LOCKED: protocol violation; set err_o and return to UNLOCKED.
  - This keeps the FPU-side request stable until granted.
- Handshake (fpu_req_o & fpu_gnt_i):
  - Push sel into the FIFO.
  - rr_ptr <= (sel+1) mod NUM_REQ.
- Response (fpu_rvalid_i):
  - rvalid_o[head]=1 in the same cycle; rdata_o and rflags_o pass through.
  - Pop the FIFO.
- Full (count==MAX_OUTSTANDING):
  - fpu_req_o forced 0, no grant, even if a pop occurs in the same cycle (deterministic, no full-bypass).
  - The lock is unaffected.
- Simultaneous push and pop when not full: count unchanged; both pointers advance mod MAX_OUTSTANDING.
- fpu_rvalid_i with FIFO empty: no rvalid_o raised, err_o set, count stays 0.
- busy_o = (count != 0) | (|req_i).
- err_o clears only on reset.

Optional Feature:
- Macro: RV32IMF_APU_ARB_PRIO_EN.
- Defined: requester 0 has strict priority.
  - If req_i[0]=1 and lock=0, sel=0 regardless of rr_ptr.
  - Requesters 1..NUM_REQ-1 round-robin among themselves; rr_ptr only updates on grants to them.
- Undefined: pure round-robin as above.
- The lock rule applies in both modes.

Test Plan:
- Single request: req_i=2'b01, fpu_gnt_i=1, op=6'h03 -> fpu_op_o=03, gnt_o=01 same cycle; fpu_rvalid_i with rdata=32'h3F800000 three cycles later -> rvalid_o=01, rdata_o=3F800000, busy_o drops the next cycle.
- Fairness: req_i=2'b11 held, fpu_gnt_i=1 every cycle, rvalid every cycle -> grant order 0,1,0,1; in PRIO_EN build -> 0,0,0,0.
- Lock: req_i=01 with fpu_gnt_i=0 for 3 cycles, req_i[1] rises in cycle 2 -> sel stays 0; gnt_o=01 when fpu_gnt_i=1; requester 1 is granted on the next handshake.
- Full: MAX_OUTSTANDING=4, four grants with no rvalid -> fpu_req_o=0 on the 5th request; one rvalid -> the request is granted the cycle after the pop.
- Out-of-order routing: grants to 1, then 0, then 1 -> three rvalids route to rvalid_o=10, 01, 10.
- Errors: fpu_rvalid_i with an empty FIFO -> err_o=1, rvalid_o=00; err_o held until rst_i. Asserting rst_i mid-lock -> all outputs 0 immediately.
